// File: rtl/agu_pc_gen.sv
// agu_pc_gen: parametrised RV32I/RV64I fetch-PC address generation unit.
// Holds the fetch PC, offers it over a valid/ready handshake, advances
// sequentially or redirects for branch/JAL/JALR, and parks in a trap state
// on a misaligned redirect target until acknowledged.
// Optional build macro: COMPRESSED_EN (adds instr_len16, 2-byte steps and
// 2-byte alignment).
module agu_pc_gen #(
  parameter int unsigned           XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic            CLK,
  input  logic            _Rest,
  input  logic            PCWre,
  input  logic            addr_ready,
  output logic            addr_valid,
  output logic [XLEN-1:0] address,
  input  logic            redirect_valid,
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
`ifdef COMPRESSED_EN
  input  logic            instr_len16,
`endif
  output logic [XLEN-1:0] link_addr,
  output logic            trap,
  output logic [XLEN-1:0] trap_pc,
  input  logic            trap_ack
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'b00,
    SRC_BR   = 2'b01,
    SRC_JAL  = 2'b10,
    SRC_JALR = 2'b11
  } src_e;

  state_e          state;
  src_e            src;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] target;
  logic            take_redirect;
  logic            misaligned;

  assign src = src_e'(pc_src);

  // Sequential increment: one instruction length.
  always_comb begin
    step = XLEN'(4);
`ifdef COMPRESSED_EN
    if (instr_len16) step = XLEN'(2);
`endif
  end

  assign link_addr = address + step;

  // Redirect target and whether the redirect is effective.
  always_comb begin
    target        = address + imm;
    take_redirect = 1'b0;
    unique case (src)
      SRC_SEQ:  take_redirect = 1'b0;
      SRC_BR:   take_redirect = redirect_valid & branch_taken;
      SRC_JAL:  take_redirect = redirect_valid;
      SRC_JALR: begin
        target        = (rs1 + imm) & ~XLEN'(1);
        take_redirect = redirect_valid;
      end
      default:  take_redirect = 1'b0;
    endcase
  end

  // Alignment check on the redirect target.
  always_comb begin
`ifdef COMPRESSED_EN
    misaligned = target[0];
`else
    misaligned = |target[1:0];
`endif
  end

  // Control FSM with registered PC, handshake and trap outputs.
  always_ff @(posedge CLK) begin
    if (_Rest) begin
      state      <= BOOT;
      address    <= RESET_VECTOR;
      addr_valid <= 1'b0;
      trap       <= 1'b0;
      trap_pc    <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state      <= RUN;
          addr_valid <= 1'b1;
        end
        RUN: begin
          if (PCWre) begin
            if (take_redirect) begin
              if (misaligned) begin
                state      <= TRAP;
                trap       <= 1'b1;
                trap_pc    <= target;
                addr_valid <= 1'b0;
              end else begin
                address <= target;
              end
            end else if (addr_ready) begin
              address <= link_addr;
            end
          end
        end
        TRAP: begin
          if (PCWre && trap_ack) begin
            state      <= RUN;
            address    <= TRAP_VECTOR;
            trap       <= 1'b0;
            addr_valid <= 1'b1;
          end
        end
        default: begin
          state      <= BOOT;
          address    <= RESET_VECTOR;
          addr_valid <= 1'b0;
          trap       <= 1'b0;
          trap_pc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agu_pc_gen.sv
// Testbench for agu_pc_gen (XLEN=32, RESET_VECTOR=0, TRAP_VECTOR=0x100).
// Table of per-cycle stimulus with expected post-edge state, plus hand
// sequences; expectations go into a scoreboard queue when driven and are
// compared one edge later.
module tb_agu_pc_gen;

  localparam int unsigned XLEN = 32;

  logic            CLK = 1'b0;
  logic            _Rest;
  logic            PCWre;
  logic            addr_ready;
  logic            addr_valid;
  logic [XLEN-1:0] address;
  logic            redirect_valid;
  logic [1:0]      pc_src;
  logic            branch_taken;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            instr_len16;
  logic [XLEN-1:0] link_addr;
  logic            trap;
  logic [XLEN-1:0] trap_pc;
  logic            trap_ack;

  agu_pc_gen #(
    .XLEN        (XLEN),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (32'h100)
  ) dut (
    .CLK           (CLK),
    ._Rest         (_Rest),
    .PCWre         (PCWre),
    .addr_ready    (addr_ready),
    .addr_valid    (addr_valid),
    .address       (address),
    .redirect_valid(redirect_valid),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .imm           (imm),
    .rs1           (rs1),
`ifdef COMPRESSED_EN
    .instr_len16   (instr_len16),
`endif
    .link_addr     (link_addr),
    .trap          (trap),
    .trap_pc       (trap_pc),
    .trap_ack      (trap_ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        we;
    logic        rdy;
    logic        rv;
    logic [1:0]  src;
    logic        bt;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        ack;
    logic        len16;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_trap;
    logic [31:0] e_tpc;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_addr;
  logic        have_last = 1'b0;

  function automatic vec_t mk(logic rst, logic we, logic rdy, logic rv,
                              logic [1:0] src, logic bt, logic [31:0] im,
                              logic [31:0] r1, logic ack, logic len16,
                              logic [31:0] ea, logic ev, logic et,
                              logic [31:0] etp);
    vec_t v;
    v.rst = rst; v.we = we; v.rdy = rdy; v.rv = rv; v.src = src; v.bt = bt;
    v.imm = im; v.rs1 = r1; v.ack = ack; v.len16 = len16;
    v.e_addr = ea; v.e_valid = ev; v.e_trap = et; v.e_tpc = etp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus away from the active edge and queue its
  // expected post-edge state; link_addr is combinational so check it now.
  task automatic go(input vec_t v);
    logic [31:0] st;
    @(negedge CLK);
    _Rest          = v.rst;
    PCWre          = v.we;
    addr_ready     = v.rdy;
    redirect_valid = v.rv;
    pc_src         = v.src;
    branch_taken   = v.bt;
    imm            = v.imm;
    rs1            = v.rs1;
    trap_ack       = v.ack;
    instr_len16    = v.len16;
    st = 32'd4;
`ifdef COMPRESSED_EN
    if (v.len16) st = 32'd2;
`endif
    #1;
    if (have_last) chk("link_addr", link_addr, last_addr + st);
    sb.push_back(v);
    last_addr = v.e_addr;
    have_last = 1'b1;
  endtask

  // Scoreboard: compare the oldest queued expectation just after each edge.
  always @(posedge CLK) begin : mon
    vec_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("address", address, e.e_addr);
      chk("addr_valid", {31'b0, addr_valid}, {31'b0, e.e_valid});
      chk("trap", {31'b0, trap}, {31'b0, e.e_trap});
      if (e.e_trap || e.rst) chk("trap_pc", trap_pc, e.e_tpc);
    end
  end

  initial begin
    _Rest = 1'b1; PCWre = 1'b0; addr_ready = 1'b0; redirect_valid = 1'b0;
    pc_src = 2'b00; branch_taken = 1'b0; imm = '0; rs1 = '0;
    trap_ack = 1'b0; instr_len16 = 1'b0;

`ifndef COMPRESSED_EN
    // rst we rdy rv src bt imm rs1 ack len16 | addr valid trap tpc
    tbl.push_back(mk(1,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,0,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,1,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h4,1,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h8,1,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'hC,1,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h10,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd2,0,32'h10,32'h0,0,0, 32'h20,1,0,32'h0));
    tbl.push_back(mk(0,1,0,0,2'd0,0,32'h0,32'h0,0,0, 32'h20,1,0,32'h0));
    tbl.push_back(mk(0,1,0,0,2'd0,0,32'h0,32'h0,0,0, 32'h20,1,0,32'h0));
    tbl.push_back(mk(0,1,0,0,2'd0,0,32'h0,32'h0,0,0, 32'h20,1,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h24,1,0,32'h0));
    tbl.push_back(mk(0,0,1,1,2'd2,0,32'h100,32'h0,0,0, 32'h24,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd3,0,32'h0,32'h40,0,0, 32'h40,1,0,32'h0));
    tbl.push_back(mk(0,1,0,1,2'd1,1,32'hFFFFFFF8,32'h0,0,0, 32'h38,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd2,0,32'h8,32'h0,0,0, 32'h40,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd1,0,32'hFFFFFFF8,32'h0,0,0, 32'h44,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd2,0,32'hFFFFFFFC,32'h0,0,0, 32'h40,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd3,0,32'h0,32'h1001,0,0, 32'h1000,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd3,0,32'h0,32'h40,0,0, 32'h40,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd0,0,32'h80,32'h0,0,0, 32'h44,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd2,0,32'hFFFFFFFC,32'h0,0,0, 32'h40,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd2,0,32'h6,32'h0,0,0, 32'h40,0,1,32'h46));
    tbl.push_back(mk(0,0,1,0,2'd0,0,32'h0,32'h0,1,0, 32'h40,0,1,32'h46));
    tbl.push_back(mk(0,1,1,1,2'd2,0,32'h100,32'h0,0,0, 32'h40,0,1,32'h46));
    tbl.push_back(mk(0,1,0,0,2'd0,0,32'h0,32'h0,1,0, 32'h100,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd3,0,32'h0,32'hFFFFFFFC,0,0, 32'hFFFFFFFC,1,0,32'h0));
    tbl.push_back(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,1,0,32'h0));
    tbl.push_back(mk(0,1,1,1,2'd3,0,32'h1,32'h1,0,0, 32'h0,0,1,32'h2));
    tbl.push_back(mk(1,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,0,0,32'h0));
    tbl.push_back(mk(0,0,0,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,1,0,32'h0));

    for (int unsigned i = 0; i < tbl.size(); i++) go(tbl[i]);

    // Target sum wraps modulo 2^32, then reset in the middle of a stalled
    // handshake, then JAL whose target has only bit1 set.
    go(mk(0,1,1,1,2'd3,0,32'h20,32'hFFFFFFF0,0,0, 32'h10,1,0,32'h0));
    go(mk(0,1,0,0,2'd0,0,32'h0,32'h0,0,0, 32'h10,1,0,32'h0));
    go(mk(1,1,0,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,0,0,32'h0));
    go(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,1,0,32'h0));
    go(mk(0,1,1,1,2'd2,0,32'h2,32'h0,0,0, 32'h0,0,1,32'h2));
    go(mk(0,1,1,0,2'd0,0,32'h0,32'h0,1,0, 32'h100,1,0,32'h0));
`else
    // Compressed build: 2-byte steps and 2-byte alignment.
    go(mk(1,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,0,0,32'h0));
    go(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h0,1,0,32'h0));
    go(mk(0,1,1,1,2'd2,0,32'h10,32'h0,0,0, 32'h10,1,0,32'h0));
    go(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,1, 32'h12,1,0,32'h0));
    go(mk(0,1,1,1,2'd2,0,32'h2,32'h0,0,0, 32'h14,1,0,32'h0));
    go(mk(0,1,1,1,2'd3,0,32'h0,32'h33,0,0, 32'h32,1,0,32'h0));
    go(mk(0,1,1,0,2'd0,0,32'h0,32'h0,0,0, 32'h36,1,0,32'h0));
    go(mk(0,1,1,1,2'd2,0,32'h1,32'h0,0,1, 32'h36,0,1,32'h37));
    go(mk(0,1,1,0,2'd0,0,32'h0,32'h0,1,0, 32'h100,1,0,32'h0));
`endif

    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agu_pc_gen.md
Name: agu_pc_gen

Overview:
- Parametrised RV32I/RV64I address generation unit; the next generation after the fixed-width sequential AGU.
- Holds the fetch PC and presents it to instruction memory over a valid/ready handshake.
- Advances sequentially, or redirects for taken branch, JAL or JALR.
- Detects misaligned targets and parks in a trap state until acknowledged, then resumes at a trap vector.

Parameters:
- XLEN, 32, address/PC width (32 or 64).
- RESET_VECTOR, 0, PC loaded by reset (XLEN bits).
- TRAP_VECTOR, 'h100, PC loaded on trap acknowledge (XLEN bits).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- _Rest  in  1  synchronous active-high reset.
- PCWre  in  1  PC write enable; when 0, PC and state hold (stall).
- addr_ready  in  1  fetch side accepts address this cycle.
- addr_valid  out  1  address is a valid fetch request.
- address  out  XLEN  current fetch PC.
- redirect_valid  in  1  control-flow redirect request.
- pc_src  in  2  redirect kind: 00 none/seq, 01 branch, 10 JAL, 11 JALR.
- branch_taken  in  1  qualifies pc_src=01.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  JALR base register.
- link_addr  out  XLEN  address+STEP, combinational, for rd of JAL/JALR.
- trap  out  1  misaligned-target trap pending.
- trap_pc  out  XLEN  offending target address.
- trap_ack  in  1  trap handled; resume at TRAP_VECTOR.

Behaviour:
- Reset (_Rest=1 at edge):
  - Overrides everything, including mid-handshake and TRAP.
  - address=RESET_VECTOR, addr_valid=0, trap=0, trap_pc=0, state=BOOT.
- STEP = 4; with COMPRESSED_EN, STEP = instr_len16 ? 2 : 4.
- States: BOOT, RUN, TRAP.
- BOOT:
  - Next edge goes to RUN with addr_valid=1; address unchanged.
  - One-cycle reset-to-valid latency; PCWre ignored.
- RUN, PCWre=0: all registers hold; addr_valid stays 1 (request held stable).
- RUN, PCWre=1, priority order:
  1. redirect_valid=1 with effective redirect:
     - Target per kind: branch with branch_taken=1 -> address+imm; JAL -> address+imm; JALR -> (rs1+imm) with bit0 forced 0.
     - Redirect is accepted regardless of addr_ready (flushes the pending fetch).
  2. redirect_valid=1 with pc_src=00, or pc_src=01 with branch_taken=0: treated as sequential.
  3. Sequential: if addr_ready=1, address <= address+STEP; else hold.
- Alignment check on every redirect target; misaligned if target[1:0]!=00 (COMPRESSED_EN: target[0]!=0).
  - On misalign: state=TRAP, trap=1, trap_pc=target, addr_valid=0, address unchanged.
- TRAP:
  - redirect_valid and addr_ready ignored.
  - trap_ack=1 with PCWre=1: address=TRAP_VECTOR, trap=0, addr_valid=1, state=RUN.
  - trap_ack with PCWre=0 is ignored.
- Arithmetic is modulo 2^XLEN: address+STEP and target sums wrap silently, no trap (all-ones rounded PC + 4 -> 0).
- link_addr is always address+STEP, including in TRAP and BOOT.
- addr_valid never drops in RUN except on entry to TRAP.

Optional Feature:
- COMPRESSED_EN defined:
  - Adds input instr_len16 (1 bit); STEP is 2 when it is high.
  - Alignment requirement relaxes to 2-byte.
- COMPRESSED_EN undefined:
  - No instr_len16 port; STEP fixed at 4.
  - 4-byte alignment enforced; any target with bits[1:0]!=00 traps.

Test Plan:
- Reset with RESET_VECTOR=0, then hold PCWre=1, addr_ready=1 for 4 cycles -> addr_valid rises 1 cycle after reset release; address sequence 0,4,8,12,16.
- RUN at address=0x20, addr_ready=0, PCWre=1 for 3 cycles, then addr_ready=1 -> address holds at 0x20 for 3 cycles, then 0x24.
- Redirect tests at address=0x40:
  - Branch imm=-8, branch_taken=1 -> 0x38.
  - Branch imm=-8, branch_taken=0 -> 0x44.
  - JALR rs1=0x1001, imm=0 -> 0x1000; link_addr=0x44 before the edge.
- Misalign (COMPRESSED_EN off): JAL at 0x40 with imm=6 -> trap=1, trap_pc=0x46, addr_valid=0, address stays 0x40. trap_ack with PCWre=0 -> no change. trap_ack with PCWre=1 -> address=0x100, addr_valid=1, trap=0.
- Wrap and reset:
  - XLEN=32, address=0xFFFFFFFC, sequential advance -> 0x00000000, no trap.
  - _Rest asserted while in TRAP -> next cycle address=RESET_VECTOR, trap=0, addr_valid=0.
- COMPRESSED_EN on:
  - instr_len16=1 from 0x10 -> 0x12.
  - JAL imm=2 from 0x12 -> 0x14, no trap.
  - JALR rs1=0x33, imm=0 -> 0x32.
